// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-to-UART transmit path.
// Also used by uart_baud_tick; a future RX block can reuse it too.
package fifo_uart_tx_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } tx_state_e;

    localparam int unsigned DATA_BITS   = 8;
    localparam logic        START_LEVEL = 1'b0;
    localparam logic        STOP_LEVEL  = 1'b1;
    localparam logic        IDLE_LEVEL  = 1'b1;

    // Ceiling log2, used for counter widths; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps.
// It ticks on the last count of each bit. The clear input holds it at 0.
module uart_baud_tick
    import fifo_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (clog2(CLKS_PER_BIT) > 0) ? clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign tick = !clear && (count_q == LAST_CNT);

    always_comb begin
        count_d = count_q;
        if (clear || tick) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a first-word-fall-through FIFO and sends them as 8N1 UART frames.
// Multi-byte words go out most significant byte first.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ENABLE,
    input  logic [WIDTH-1:0] FIFO_DATA,
    input  logic             FIFO_EMPTY,
    output logic             FIFO_RE,
    output logic             TXD,
    output logic             BUSY
);

    localparam int unsigned NBYTES = WIDTH / DATA_BITS;
    localparam int unsigned BYTE_W = (NBYTES > 1) ? clog2(NBYTES) : 1;
    localparam int unsigned BIT_W  = clog2(DATA_BITS);

    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic              LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_e         state_q, state_d;
    logic [WIDTH-1:0]  word_q, word_d;
    logic [BYTE_W-1:0] byte_idx_q, byte_idx_d;
    logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
    logic              stop_idx_q, stop_idx_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;

    logic                 baud_clear;
    logic                 baud_tick;
    logic                 pop;
    logic [BIT_W-1:0]     bit_nxt;
    logic [DATA_BITS-1:0] cur_byte;

    // The word is shifted left a byte at a time, so the byte on air is always the top one.
    assign cur_byte = word_q[WIDTH-1 -: DATA_BITS];
    assign bit_nxt  = bit_idx_q + BIT_W'(1);

    assign pop     = (state_q == StIdle) && ENABLE && !FIFO_EMPTY;
    assign FIFO_RE = pop && RST_N;
    assign TXD     = txd_q;
    assign BUSY    = busy_q;

    // Every non-idle transition lands on a wrap, so holding in idle restarts each state at 0.
    assign baud_clear = (state_q == StIdle);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk  (CLK),
        .rst_n(RST_N),
        .clear(baud_clear),
        .tick (baud_tick)
    );

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        txd_d      = txd_q;
        busy_d     = busy_q;

        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    word_d     = FIFO_DATA;
                    byte_idx_d = LAST_BYTE;
                    busy_d     = 1'b1;
                    txd_d      = START_LEVEL;
                    state_d    = StStart;
                end
            end
            StStart: begin
                if (baud_tick) begin
                    bit_idx_d = '0;
                    txd_d     = cur_byte[0];
                    state_d   = StData;
                end
            end
            StData: begin
                if (baud_tick) begin
                    if (bit_idx_q == LAST_BIT) begin
                        stop_idx_d = 1'b0;
                        txd_d      = STOP_LEVEL;
                        state_d    = StStop;
                    end else begin
                        bit_idx_d = bit_nxt;
                        txd_d     = cur_byte[bit_nxt];
                    end
                end
            end
            StStop: begin
                if (baud_tick) begin
                    if (stop_idx_q != LAST_STOP) begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end else if (byte_idx_q != '0) begin
                        byte_idx_d = byte_idx_q - BYTE_W'(1);
                        word_d     = word_q << DATA_BITS;
                        txd_d      = START_LEVEL;
                        state_d    = StStart;
                    end else begin
                        txd_d   = IDLE_LEVEL;
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= StIdle;
            word_q     <= '0;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            txd_q      <= IDLE_LEVEL;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx. It drives three configurations: 8-bit/1 stop, 16-bit/1 stop and 8-bit/2 stop.
// A timing model gives the expected TXD, BUSY and FIFO_RE on every cycle.
module tb_fifo_uart_tx;

    localparam int N = 4;

    logic CLK    = 1'b0;
    logic RST_N  = 1'b1;
    logic ENABLE = 1'b1;

    logic [2:0] fempty;
    logic [2:0] re_w;
    logic [2:0] txd_w;
    logic [2:0] busy_w;
    logic [7:0]  fd0;
    logic [15:0] fd1;
    logic [7:0]  fd2;

    logic [15:0] fmem [3][8];
    logic [2:0]  fhead [3];
    int          fcnt [3];
    int          pend [3];
    int          npop [3];
    int          lastpop [3];
    int          act [3];
    logic [15:0] mword [3];

    int cyc    = 0;
    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    always #5 CLK = ~CLK;

    assign fempty[0] = (fcnt[0] == 0);
    assign fempty[1] = (fcnt[1] == 0);
    assign fempty[2] = (fcnt[2] == 0);
    assign fd0 = fmem[0][fhead[0]][7:0];
    assign fd1 = fmem[1][fhead[1]];
    assign fd2 = fmem[2][fhead[2]][7:0];

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(N), .STOP_BITS(1)) dut0 (
        .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .FIFO_DATA(fd0), .FIFO_EMPTY(fempty[0]),
        .FIFO_RE(re_w[0]), .TXD(txd_w[0]), .BUSY(busy_w[0])
    );
    fifo_uart_tx #(.WIDTH(16), .CLKS_PER_BIT(N), .STOP_BITS(1)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .FIFO_DATA(fd1), .FIFO_EMPTY(fempty[1]),
        .FIFO_RE(re_w[1]), .TXD(txd_w[1]), .BUSY(busy_w[1])
    );
    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(N), .STOP_BITS(2)) dut2 (
        .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .FIFO_DATA(fd2), .FIFO_EMPTY(fempty[2]),
        .FIFO_RE(re_w[2]), .TXD(txd_w[2]), .BUSY(busy_w[2])
    );

    function automatic int nb(int i);
        return (i == 1) ? 2 : 1;
    endfunction

    function automatic int sb(int i);
        return (i == 2) ? 2 : 1;
    endfunction

    // Line level k cycles after the first start-bit cycle of the word mword[i].
    function automatic logic model_txd(int i, int k);
        int fl, b, w, slot, sh;
        logic [7:0] byt;
        fl   = (9 + sb(i)) * N;
        b    = k / fl;
        w    = k % fl;
        slot = w / N;
        sh   = 8 * (nb(i) - 1 - b);
        byt  = 8'(mword[i] >> sh);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return byt[slot-1];
        return 1'b1;
    endfunction

    function automatic logic [127:0] expand(logic [9:0] f0, logic [9:0] f1, int nf);
        logic [127:0] e;
        e = '0;
        for (int f = 0; f < nf; f++)
            for (int j = 0; j < 10; j++)
                for (int r = 0; r < N; r++)
                    e[(f * 10 + j) * N + r] = (f == 0) ? f0[j] : f1[j];
        return e;
    endfunction

    task automatic check_int(string name, int idx, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s[dut%0d] @cyc %0d: got %0d, expected %0d", name, idx, cyc, got, exp);
        end
    endtask

    task automatic check_vec(string name, int idx, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[dut%0d]: got %h, expected %h", name, idx, got, exp);
        end
    endtask

    // Apply FIFO pops one time unit after the edge on which the DUT consumed the head.
    always @(posedge CLK) begin
        cyc++;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (pend[i] != 0) begin
                fhead[i] = fhead[i] + 3'd1;
                fcnt[i]  = fcnt[i] - 1;
                pend[i]  = 0;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_on) begin
            for (int i = 0; i < 3; i++) begin : per_dut
                logic e_txd, e_busy, e_re;
                int k, total;
                if (!RST_N) begin
                    act[i] = 0;
                    e_txd  = 1'b1;
                    e_busy = 1'b0;
                    e_re   = 1'b0;
                end else begin
                    k      = cyc - lastpop[i] - 1;
                    total  = nb(i) * (9 + sb(i)) * N;
                    e_busy = (act[i] != 0) && (k >= 0) && (k < total);
                    e_txd  = e_busy ? model_txd(i, k) : 1'b1;
                    e_re   = !e_busy && ENABLE && (fcnt[i] > 0);
                end
                check_int("txd", i, int'(txd_w[i]), int'(e_txd));
                check_int("busy", i, int'(busy_w[i]), int'(e_busy));
                check_int("fifo_re", i, int'(re_w[i]), int'(e_re));
                if (RST_N && re_w[i]) begin
                    lastpop[i] = cyc;
                    act[i]     = 1;
                    mword[i]   = fmem[i][fhead[i]];
                    pend[i]    = 1;
                    npop[i]++;
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #2;
    endtask

    task automatic sample();
        @(negedge CLK);
        #1;
    endtask

    task automatic push(int i, logic [15:0] w);
        fmem[i][fhead[i] + 3'(fcnt[i])] = w;
        fcnt[i]++;
    endtask

    task automatic wait_pop(int i, int budget, string name, output int t);
        int n0;
        n0 = npop[i];
        t  = -1;
        for (int c = 0; c < budget && npop[i] == n0; c++) sample();
        if (npop[i] != n0) begin
            t = lastpop[i];
        end else begin
            checks++;
            errors++;
            $display("FAIL %s[dut%0d]: no pop within %0d cycles, expected one", name, i, budget);
        end
    endtask

    task automatic capture(int i, int len, output logic [127:0] cap);
        cap = '0;
        for (int j = 0; j < len; j++) begin
            sample();
            cap[j] = txd_w[i];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int t0, t1, t2, te, n_before;
        logic [127:0] cap;
        for (int i = 0; i < 3; i++) begin
            fhead[i] = 3'd0; fcnt[i] = 0; pend[i] = 0; npop[i] = 0;
            lastpop[i] = 0; act[i] = 0; mword[i] = 16'h0;
            for (int j = 0; j < 8; j++) fmem[i][j] = 16'h0;
        end

        // Reset with FIFOs empty and ENABLE high, then 100 idle cycles.
        #1 RST_N = 1'b0;
        chk_on = 1'b1;
        repeat (3) next_cycle();
        RST_N = 1'b1;
        repeat (100) next_cycle();
        for (int i = 0; i < 3; i++) begin
            check_int("reset_no_pop", i, npop[i], 0);
            check_int("reset_txd_high", i, int'(txd_w[i]), 1);
            check_int("reset_busy_low", i, int'(busy_w[i]), 0);
        end

        // Single byte 0xA5.
        next_cycle();
        push(0, 16'h00A5);
        wait_pop(0, 5, "single_pop", t0);
        capture(0, 40, cap);
        check_vec("single_frame", 0, cap, expand(10'b1101001010, 10'b0, 1));
        check_int("single_busy_last_stop", 0, int'(busy_w[0]), 1);
        sample();
        check_int("single_busy_fall", 0, int'(busy_w[0]), 0);
        check_int("single_one_pop", 0, npop[0], 1);

        // 16-bit word 0x12C3: 0x12 frame then 0xC3 frame.
        next_cycle();
        push(1, 16'h12C3);
        wait_pop(1, 5, "multi_pop", t0);
        capture(1, 80, cap);
        check_vec("multi_frames", 1, cap, expand(10'b1000100100, 10'b1110000110, 2));
        check_int("multi_busy_last_stop", 1, int'(busy_w[1]), 1);
        sample();
        check_int("multi_busy_fall", 1, int'(busy_w[1]), 0);
        check_int("multi_one_pop", 1, npop[1], 1);

        // Two words back to back with two stop bits: 44-cycle frame plus the pop cycle.
        next_cycle();
        push(2, 16'h0001);
        push(2, 16'h0080);
        wait_pop(2, 5, "b2b_first_pop", t1);
        wait_pop(2, 60, "b2b_second_pop", t2);
        check_int("b2b_pop_spacing", 2, t2 - t1, 45);
        repeat (50) next_cycle();
        check_int("b2b_two_pops", 2, npop[2], 2);
        check_int("b2b_idle_busy", 2, int'(busy_w[2]), 0);

        // ENABLE dropped in the middle of the word 0x3C while 0x55 waits in the FIFO.
        next_cycle();
        push(0, 16'h003C);
        push(0, 16'h0055);
        wait_pop(0, 5, "en_first_pop", t0);
        n_before = npop[0];
        repeat (10) next_cycle();
        ENABLE = 1'b0;
        repeat (60) next_cycle();
        check_int("en_no_new_pop", 0, npop[0], n_before);
        check_int("en_word_left", 0, fcnt[0], 1);
        check_int("en_idle_busy", 0, int'(busy_w[0]), 0);
        next_cycle();
        ENABLE = 1'b1;
        te = cyc;
        sample();
        check_int("en_repop_count", 0, npop[0], n_before + 1);
        check_int("en_repop_cycle", 0, lastpop[0], te);
        repeat (45) next_cycle();

        // Asynchronous reset in the middle of the data bits of 0xF0.
        next_cycle();
        push(0, 16'h00F0);
        wait_pop(0, 5, "arst_pop", t0);
        repeat (9) next_cycle();
        check_int("arst_busy_before", 0, int'(busy_w[0]), 1);
        @(negedge CLK);
        #3;
        RST_N = 1'b0;
        #1;
        check_int("arst_txd_immediate", 0, int'(txd_w[0]), 1);
        check_int("arst_busy_immediate", 0, int'(busy_w[0]), 0);
        repeat (2) next_cycle();
        push(0, 16'h000F);
        RST_N = 1'b1;
        wait_pop(0, 5, "arst_repop", t0);
        capture(0, 40, cap);
        check_vec("arst_clean_frame", 0, cap, expand(10'b1000011110, 10'b0, 1));
        repeat (5) next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
